// File: rtl/fx_pt_add_rnd_pipe.sv
// fx_pt_add_rnd_pipe: pipelined fixed-point adder with run-time rounding and saturate/wrap
module fx_pt_add_rnd_pipe #(
  parameter int SN     = 1,
  parameter int AIW    = 9,
  parameter int AFW    = 8,
  parameter int BIW    = 10,
  parameter int BFW    = 9,
  parameter int SIW    = (AIW > BIW ? AIW : BIW) + 2,
  parameter int SFW    = 7,
  parameter int LAT    = 2,
  parameter int SAT_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AIW+AFW-1:0]   in_a,
  input  logic [BIW+BFW-1:0]   in_b,
  input  logic [1:0]           rnd_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SIW+SFW-1:0]   sum,
  output logic                 ovf
);
  localparam int MFW = AFW > BFW ? AFW : BFW;
  // one spare bit beyond the exact-sum width keeps unsigned sums non-negative when viewed as signed
  localparam int EW  = (AIW > BIW ? AIW : BIW) + 2 + MFW;
  localparam int D   = MFW > SFW ? MFW - SFW : 0;
  localparam int SHL = SFW > MFW ? SFW - MFW : 0;
  localparam int OW  = SIW + SFW;
  localparam int RW  = EW + SHL + 1 > OW + 1 ? EW + SHL + 1 : OW + 1;
  localparam int RN  = LAT > 1 ? LAT - 1 : 1;
  localparam logic signed [RW-1:0] MAXV = SN != 0 ? RW'({(OW-1){1'b1}}) : RW'({OW{1'b1}});
  localparam logic signed [RW-1:0] MINV = SN != 0 ? ~MAXV : '0;

  logic                  en, acc, p_v, hi, lo;
  logic signed [EW-1:0]  a_x, b_x, s, p_s;
  logic [1:0]            p_m;
  logic signed [RW-1:0]  r;
  logic [OW-1:0]         res;
  logic [RN-1:0]         v_q, ovf_q;
  logic [OW-1:0]         sum_q [RN];

  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;
  assign acc      = in_valid && en;
  assign a_x      = (SN != 0 ? EW'($signed(in_a)) : EW'($unsigned(in_a))) <<< (MFW - AFW);
  assign b_x      = (SN != 0 ? EW'($signed(in_b)) : EW'($unsigned(in_b))) <<< (MFW - BFW);
  assign s        = a_x + b_x;

  if (LAT > 1) begin : g_in_reg
    // register the exact sum and its rounding mode so rounding starts from a flop
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        p_v <= 1'b0;
        p_s <= '0;
        p_m <= '0;
      end else if (en) begin
        p_v <= acc;
        p_s <= s;
        p_m <= rnd_mode;
      end
  end else begin : g_in_comb
    assign p_v = acc;
    assign p_s = s;
    assign p_m = rnd_mode;
  end

  if (D > 0) begin : g_rnd
    localparam logic [D-1:0] H = D'(1) << (D - 1);
    logic signed [EW-1:0] q;
    logic [D-1:0]         rem;
    logic                 inc;
    // floor-shift then add the mode-dependent increment at full width so the carry cannot wrap
    always_comb begin
      q   = p_s >>> D;
      rem = p_s[D-1:0];
      inc = p_m == 2'd1 ? rem >= H :
            p_m == 2'd2 ? (rem > H || (rem == H && q[0])) :
            p_m == 2'd3 ? (p_s[EW-1] && rem != '0) : 1'b0;
      r   = RW'(q) + RW'(inc);
    end
  end else begin : g_pad
    assign r = RW'(p_s) <<< SHL;
  end

  // range check against the output format, then clamp or keep low bits
  always_comb begin
    hi  = r > MAXV;
    lo  = r < MINV;
    res = SAT_EN != 0 && hi ? MAXV[OW-1:0] : SAT_EN != 0 && lo ? MINV[OW-1:0] : r[OW-1:0];
  end

  // result shift register; every stage advances together and bubbles are kept
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      v_q   <= '0;
      ovf_q <= '0;
      for (int i = 0; i < RN; i++) sum_q[i] <= '0;
    end else if (en) begin
      for (int i = RN - 1; i > 0; i--) begin
        v_q[i]   <= v_q[i-1];
        ovf_q[i] <= ovf_q[i-1];
        sum_q[i] <= sum_q[i-1];
      end
      v_q[0]   <= p_v;
      ovf_q[0] <= hi || lo;
      sum_q[0] <= res;
    end

  assign out_valid = v_q[RN-1];
  assign ovf       = ovf_q[RN-1];
  assign sum       = sum_q[RN-1];
endmodule

// File: tb/tb_fx_pt_add_rnd_pipe.sv
// tb_fx_pt_add_rnd_pipe: scoreboard bench for the fixed-point adder in three range configurations
module tb_fx_pt_add_rnd_pipe;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [16:0] in_a;
  logic [18:0] in_b;
  logic [1:0]  rnd_mode;
  logic        out_ready = 1'b1;
  logic        ir0, ir1, ir2, ov0, ov1, ov2, f0, f1, f2;
  logic [18:0] s0;
  logic [15:0] s1, s2;
  int          checks, failures, rdy_mode, rcnt;
  bit [37:0]   q[$];
  bit          stalled;
  logic [18:0] held_s;
  logic        held_f;

  fx_pt_add_rnd_pipe u0 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .in_a(in_a),
    .in_b(in_b), .rnd_mode(rnd_mode), .out_valid(ov0), .out_ready(out_ready), .sum(s0), .ovf(f0));
  fx_pt_add_rnd_pipe #(.SIW(9), .SAT_EN(1)) u1 (.clk(clk), .rst(rst), .in_valid(in_valid),
    .in_ready(ir1), .in_a(in_a), .in_b(in_b), .rnd_mode(rnd_mode), .out_valid(ov1),
    .out_ready(out_ready), .sum(s1), .ovf(f1));
  fx_pt_add_rnd_pipe #(.SIW(9), .SAT_EN(0)) u2 (.clk(clk), .rst(rst), .in_valid(in_valid),
    .in_ready(ir2), .in_a(in_a), .in_b(in_b), .rnd_mode(rnd_mode), .out_valid(ov2),
    .out_ready(out_ready), .sum(s2), .ovf(f2));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: values in units of 2^-9, floor division by 4 for the two dropped bits,
  // then the rounding rule, then range handling for a Q(siw).7 result.
  function automatic void model(input bit [37:0] e, input int siw, input bit sat,
                                output logic [63:0] rs, output logic [63:0] ro);
    longint sa, sb, tot, fl, rem, v, mx, mn;
    bit inc;
    int ow;
    logic [1:0] m;
    m   = e[37:36];
    sa  = longint'($signed(e[35:19])) * 2;
    sb  = longint'($signed(e[18:0]));
    tot = sa + sb;
    fl  = tot >>> 2;
    rem = tot - fl * 4;
    inc = m == 2'd1 ? rem >= 2 : m == 2'd2 ? (rem > 2 || (rem == 2 && fl[0])) :
          m == 2'd3 ? (tot < 0 && rem != 0) : 1'b0;
    v   = fl + longint'(inc);
    ow  = siw + 7;
    mx  = (64'sd1 <<< (ow - 1)) - 1;
    mn  = -mx - 1;
    ro  = 64'(v > mx || v < mn);
    if (sat && v > mx) v = mx;
    else if (sat && v < mn) v = mn;
    rs  = 64'(v & ((64'sd1 <<< ow) - 1));
  endfunction

  always @(posedge clk) begin
    #1;
    rcnt++;
    out_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? (rcnt % 3 == 0) : 1'($urandom_range(0, 1));
  end

  always @(negedge clk)
    if (rst && in_valid && ir0) q.push_back({rnd_mode, in_a, in_b});

  always @(negedge clk) begin
    bit [37:0] e;
    logic [63:0] es, eo;
    if (!rst) stalled = 1'b0;
    else begin
      chk("in_ready_en", ir0, 64'(!(ov0 && !out_ready)));
      if (stalled) begin
        chk("stall_valid", ov0, 1);
        chk("stall_sum", s0, held_s);
        chk("stall_ovf", f0, held_f);
      end
      if (ov0 && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_output actual=%0h expected=none", s0);
        end else begin
          e = q.pop_front();
          model(e, 12, 1'b1, es, eo);
          chk("sum_q12", s0, es);
          chk("ovf_q12", f0, eo);
          model(e, 9, 1'b1, es, eo);
          chk("valid_sat", ov1, 1);
          chk("sum_sat", s1, es);
          chk("ovf_sat", f1, eo);
          model(e, 9, 1'b0, es, eo);
          chk("valid_wrap", ov2, 1);
          chk("sum_wrap", s2, es);
          chk("ovf_wrap", f2, eo);
        end
      end
      stalled = ov0 && !out_ready;
      held_s  = s0;
      held_f  = f0;
    end
  end

  task automatic send(input logic [16:0] a, input logic [18:0] b, input logic [1:0] m);
    bit ok;
    int n;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    rnd_mode = m;
    n        = 0;
    do begin
      @(negedge clk);
      ok = ir0;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 100);
    if (!ok) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic lat_check(input string name);
    repeat (LAT - 1) begin
      @(negedge clk);
      chk({name, "_early"}, ov0, 0);
    end
    @(negedge clk);
    chk({name, "_valid"}, ov0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    checks = 0; failures = 0; rdy_mode = 0; rcnt = 0; stalled = 1'b0;
    rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; rnd_mode = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", ov0, 0);
    chk("rst_sum", s0, 0);
    chk("rst_ovf", f0, 0);
    chk("rst_in_ready", ir0, 1);
    rst = 1'b1;
    idle(1);
    send(17'h00180, 19'h00080, 2'd0);
    lat_check("t1_latency");
    for (int m = 0; m < 4; m++) begin
      send(17'h0, 19'h00002, 2'(m));
      send(17'h0, 19'h00006, 2'(m));
      send(17'h0, 19'h7FFFE, 2'(m));
      send(17'h0FFFF, 19'h1FFFF, 2'(m));
      send(17'h10000, 19'h40000, 2'(m));
      send(17'h0FFFF, 19'h40000, 2'(m));
    end
    idle(4);
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) send(17'($urandom), 19'($urandom), 2'($urandom));
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send(17'($urandom), 19'($urandom), 2'($urandom));
    end
    rdy_mode = 0;
    idle(8);
    send(17'h00100, 19'h00200, 2'd1);
    send(17'h00300, 19'h00400, 2'd2);
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", ov0, 0);
    chk("midrst_sum", s0, 0);
    q.delete();
    idle(2);
    rst = 1'b1;
    idle(1);
    send(17'h00180, 19'h00080, 2'd0);
    lat_check("post_rst_latency");
    n = 0;
    while (q.size() != 0 && n < 50) begin
      idle(1);
      n++;
    end
    chk("drain_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
